// File: rtl/jtag_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : jtag_mem_arb
// Brief    : Two-master (core / JTAG debug) arbiter for the data-memory port,
//            with debug-mode priority, JTAG starvation guard and read routing.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_mem_arb #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dbg_mode,
    input  logic              i_core_req,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic              i_core_wr_en,
    input  logic [DATA_W-1:0] i_core_wr_data,
    output logic              o_core_gnt,
    output logic              o_core_rd_vld,
    output logic [DATA_W-1:0] o_core_rd_data,
    input  logic              i_jtag_bus_vld,
    input  logic [ADDR_W-1:0] i_jtag_mem_addr,
    input  logic              i_jtag_mem_wr_en,
    input  logic [DATA_W-1:0] i_jtag_mem_wr_data,
    output logic              o_jtag_bus_rdy,
    output logic              o_jtag_rd_vld,
    output logic [DATA_W-1:0] o_jtag_mem_rd_data,
    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wr_en,
    output logic [DATA_W-1:0] o_mem_wr_data,
    input  logic [DATA_W-1:0] i_mem_rd_data
);

    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic       r_rd_pend;
    logic       r_rd_owner;
    logic       w_jtag_win;
    logic       w_core_win;
    logic       w_rd_grant;

    // Reset masks both grants so nothing reaches memory while rst is high.
    always_comb begin
        w_jtag_win = i_jtag_bus_vld & ~rst &
                     (i_dbg_mode | ~i_core_req | (r_wait_cnt == C_MAX_WAIT));
        w_core_win = i_core_req & ~rst & ~w_jtag_win;
        w_rd_grant = (w_jtag_win & ~i_jtag_mem_wr_en) |
                     (w_core_win & ~i_core_wr_en);
    end

    assign o_core_gnt     = w_core_win;
    assign o_jtag_bus_rdy = w_jtag_win;
    assign o_mem_en       = w_core_win | w_jtag_win;

    always_comb begin
        o_mem_addr    = '0;
        o_mem_wr_en   = 1'b0;
        o_mem_wr_data = '0;
        if (w_jtag_win) begin
            o_mem_addr    = i_jtag_mem_addr;
            o_mem_wr_en   = i_jtag_mem_wr_en;
            o_mem_wr_data = i_jtag_mem_wr_data;
        end else if (w_core_win) begin
            o_mem_addr    = i_core_addr;
            o_mem_wr_en   = i_core_wr_en;
            o_mem_wr_data = i_core_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            if (!i_jtag_bus_vld || w_jtag_win) begin
                r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt != C_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            r_rd_pend <= w_rd_grant;
            if (w_rd_grant) begin
                r_rd_owner <= w_jtag_win;
            end
        end
    end

    // Read data is steered to its owner only; the other master sees zero.
    assign o_core_rd_vld      = r_rd_pend & ~r_rd_owner & ~rst;
    assign o_jtag_rd_vld      = r_rd_pend &  r_rd_owner & ~rst;
    assign o_core_rd_data     = o_core_rd_vld ? i_mem_rd_data : '0;
    assign o_jtag_mem_rd_data = o_jtag_rd_vld ? i_mem_rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_jtag_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_mem_arb
// Brief    : Directed self-checking bench for jtag_mem_arb with a per-cycle
//            reference model and literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_mem_arb;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              dbg_mode;
    logic              core_req;
    logic [ADDR_W-1:0] core_addr;
    logic              core_wr_en;
    logic [DATA_W-1:0] core_wr_data;
    logic              core_gnt;
    logic              core_rd_vld;
    logic [DATA_W-1:0] core_rd_data;
    logic              jtag_vld;
    logic [ADDR_W-1:0] jtag_addr;
    logic              jtag_wr_en;
    logic [DATA_W-1:0] jtag_wr_data;
    logic              jtag_rdy;
    logic              jtag_rd_vld;
    logic [DATA_W-1:0] jtag_rd_data;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    jtag_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .i_dbg_mode(dbg_mode),
        .i_core_req(core_req), .i_core_addr(core_addr), .i_core_wr_en(core_wr_en),
        .i_core_wr_data(core_wr_data), .o_core_gnt(core_gnt),
        .o_core_rd_vld(core_rd_vld), .o_core_rd_data(core_rd_data),
        .i_jtag_bus_vld(jtag_vld), .i_jtag_mem_addr(jtag_addr),
        .i_jtag_mem_wr_en(jtag_wr_en), .i_jtag_mem_wr_data(jtag_wr_data),
        .o_jtag_bus_rdy(jtag_rdy), .o_jtag_rd_vld(jtag_rd_vld),
        .o_jtag_mem_rd_data(jtag_rd_data), .o_mem_en(mem_en), .o_mem_addr(mem_addr),
        .o_mem_wr_en(mem_wr_en), .o_mem_wr_data(mem_wr_data), .i_mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: losses counts consecutive cycles JTAG asked and lost;
    // ret_owner is the master owed read data this cycle (-1 = none).
    int losses    = 0;
    int ret_owner = -1;

    always @(negedge clk) begin
        bit e_jg, e_cg, e_cv, e_jv;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        bit e_wr;
        e_jg = !rst && jtag_vld && (dbg_mode || !core_req || losses >= MAX_WAIT);
        e_cg = !rst && core_req && !e_jg;
        e_addr = '0; e_wdata = '0; e_wr = 1'b0;
        if (e_jg) begin
            e_addr = jtag_addr; e_wdata = jtag_wr_data; e_wr = jtag_wr_en;
        end else if (e_cg) begin
            e_addr = core_addr; e_wdata = core_wr_data; e_wr = core_wr_en;
        end
        e_cv = !rst && ret_owner == 0;
        e_jv = !rst && ret_owner == 1;
        chk("core_gnt", core_gnt, e_cg);
        chk("jtag_rdy", jtag_rdy, e_jg);
        chk("mem_en", mem_en, e_cg || e_jg);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wr_en", mem_wr_en, e_wr);
        chk("mem_wr_data", mem_wr_data, e_wdata);
        chk("core_rd_vld", core_rd_vld, e_cv);
        chk("jtag_rd_vld", jtag_rd_vld, e_jv);
        chk("core_rd_data", core_rd_data, e_cv ? mem_rd_data : '0);
        chk("jtag_rd_data", jtag_rd_data, e_jv ? mem_rd_data : '0);
        if (rst) begin
            losses    = 0;
            ret_owner = -1;
        end else begin
            losses    = (jtag_vld && !e_jg) ? losses + 1 : 0;
            ret_owner = (e_jg && !jtag_wr_en) ? 1 : (e_cg && !core_wr_en) ? 0 : -1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; dbg_mode = 1'b0;
        core_req = 1'b1; core_addr = 32'h4; core_wr_en = 1'b0; core_wr_data = '0;
        jtag_vld = 1'b1; jtag_addr = 32'h8; jtag_wr_en = 1'b0; jtag_wr_data = '0;
        mem_rd_data = '0;
        step();
        #2;
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_jtag_rdy", jtag_rdy, 0);
        chk("rst_mem_en", mem_en, 0);
        step();
        rst = 1'b0; core_req = 1'b0; jtag_vld = 1'b0; core_addr = '0; jtag_addr = '0;
        #2;
        chk("post_rst_outs", {core_gnt, jtag_rdy, mem_en, core_rd_vld, jtag_rd_vld, mem_wr_en}, 0);
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_wait", dut.r_wait_cnt, 0);

        // Core-only read of 0x100.
        step();
        core_req = 1'b1; core_addr = 32'h100; core_wr_en = 1'b0;
        #2;
        chk("core_rd_gnt", core_gnt, 1);
        chk("core_rd_addr", mem_addr, 32'h100);
        step();
        core_req = 1'b0; mem_rd_data = 32'hDEADBEEF;
        #2;
        chk("core_rd_vld_lit", core_rd_vld, 1);
        chk("core_rd_data_lit", core_rd_data, 32'hDEADBEEF);
        chk("core_rd_jv_lit", jtag_rd_vld, 0);

        // Normal-mode contention: core writes, JTAG reads; JTAG every 5th cycle.
        step();
        mem_rd_data = 32'h0000_ABCD;
        core_req = 1'b1; core_wr_en = 1'b1; core_addr = 32'h200; core_wr_data = 32'hC0;
        jtag_vld = 1'b1; jtag_wr_en = 1'b0; jtag_addr = 32'h300;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("starve_jtag", jtag_rdy, (i % 5) == 4);
            chk("starve_core", core_gnt, (i % 5) != 4);
            step();
        end

        // Debug mode: JTAG always first; dropping it hands the port straight back.
        dbg_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("dbg_jtag", jtag_rdy, 1);
            chk("dbg_core", core_gnt, 0);
            step();
        end
        dbg_mode = 1'b0;
        #2;
        chk("dbg_drop_core", core_gnt, 1);
        chk("dbg_drop_jtag", jtag_rdy, 0);
        step();

        // Alternating reads core 0x10, JTAG 0x20, core 0x30.
        jtag_vld = 1'b0; core_wr_en = 1'b0; core_addr = 32'h10; mem_rd_data = '0;
        #2;
        chk("alt0_core_gnt", core_gnt, 1);
        step();
        core_req = 1'b0; jtag_vld = 1'b1; jtag_addr = 32'h20; mem_rd_data = 32'h1111;
        #2;
        chk("alt1_core_vld", core_rd_vld, 1);
        chk("alt1_core_data", core_rd_data, 32'h1111);
        chk("alt1_jtag_rdy", jtag_rdy, 1);
        step();
        jtag_vld = 1'b0; core_req = 1'b1; core_addr = 32'h30; mem_rd_data = 32'h2222;
        #2;
        chk("alt2_jtag_vld", jtag_rd_vld, 1);
        chk("alt2_jtag_data", jtag_rd_data, 32'h2222);
        chk("alt2_core_vld", core_rd_vld, 0);
        step();
        core_req = 1'b0; mem_rd_data = 32'h3333;
        #2;
        chk("alt3_core_vld", core_rd_vld, 1);
        chk("alt3_core_data", core_rd_data, 32'h3333);
        chk("alt3_jtag_vld", jtag_rd_vld, 0);
        step();

        // JTAG write 0x55AA to 0x40.
        jtag_vld = 1'b1; jtag_wr_en = 1'b1; jtag_addr = 32'h40; jtag_wr_data = 32'h55AA;
        mem_rd_data = 32'h9999;
        #2;
        chk("jwr_mem_en", mem_en, 1);
        chk("jwr_wr_en", mem_wr_en, 1);
        chk("jwr_addr", mem_addr, 32'h40);
        chk("jwr_data", mem_wr_data, 32'h55AA);
        step();
        jtag_vld = 1'b0; jtag_wr_en = 1'b0;
        #2;
        chk("jwr_no_rvld", {core_rd_vld, jtag_rd_vld}, 0);

        // JTAG read aborted by reset on the following cycle.
        step();
        jtag_vld = 1'b1; jtag_addr = 32'h80;
        #2;
        chk("abort_rdy", jtag_rdy, 1);
        step();
        jtag_vld = 1'b0; rst = 1'b1; mem_rd_data = 32'h7777;
        #2;
        chk("abort_rst_vld", jtag_rd_vld, 0);
        chk("abort_rst_data", jtag_rd_data, 0);
        step();
        rst = 1'b0;
        #2;
        chk("abort_after_vld", {core_rd_vld, jtag_rd_vld, mem_en, core_gnt, jtag_rdy}, 0);
        chk("abort_after_addr", mem_addr, 0);
        chk("abort_after_wait", dut.r_wait_cnt, 0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
